// File: rtl/usb_in_ep_engine.sv
// Device-side IN transaction engine for endpoints 1..NUM_EPS.
// Decodes IN tokens addressed to this device and answers with STALL, NAK or
// DATA0/1. Reports longer than MAX_PKT go out over several transactions.
// After a DATA packet it waits for the host ACK and keeps one data toggle
// per endpoint.
module usb_in_ep_engine #(
  parameter int NUM_EPS     = 2,
  parameter int MAX_PKT     = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             dev_addr,
  input  logic [3:0]             rx_pid,
  input  logic                   rx_pid_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_valid,
  input  logic                   rx_pkt_start,
  input  logic                   rx_pkt_end,
  input  logic                   rx_crc_err,
  output logic [3:0]             tx_pid,
  output logic [7:0]             tx_data,
  output logic                   tx_data_valid,
  output logic                   tx_pkt_start,
  output logic                   tx_pkt_end,
  input  logic                   tx_ready,
  input  logic [8*NUM_EPS-1:0]   ep_data,
  input  logic [NUM_EPS-1:0]     ep_valid,
  input  logic [NUM_EPS-1:0]     ep_last,
  output logic [NUM_EPS-1:0]     ep_ready,
  input  logic [NUM_EPS-1:0]     ep_stall,
  input  logic [NUM_EPS-1:0]     ep_toggle_clr,
  output logic [NUM_EPS-1:0]     ep_done,
  output logic [NUM_EPS-1:0]     ep_retry,
  output logic                   busy
);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PKT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam logic [4:0]    NEPS = 5'(NUM_EPS);

  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  typedef enum logic [2:0] {IDLE, TOKEN, HS, TX_DATA, TX_END, WAIT_ACK} state_t;

  state_t               state;
  logic [3:0]           pid_q;
  logic [10:0]          tok_q;     // {endp, addr}; CRC5 bits are not kept
  logic [1:0]           tok_cnt;   // saturates at 3 so "too many bytes" stays visible
  logic [3:0]           sel;       // endpoint index (endp-1) being served
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tcnt;
  logic [NUM_EPS-1:0]   toggle;

  logic [3:0]           cur_pid;
  logic [10:0]          tok_nx;
  logic [1:0]           tok_cnt_nx;
  logic [3:0]           dec_idx;
  logic                 tok_ok;
  logic                 d_stall, d_valid, d_tog;
  logic                 s_valid, s_last;
  logic [7:0]           s_data;
  logic                 send, ack_hit, to_hit;
  logic [NUM_EPS-1:0]   sel_oh;

  assign busy    = (state != IDLE);
  // A PID strobe in the same cycle as the end pulse still counts.
  assign cur_pid = rx_pid_valid ? rx_pid : pid_q;

  // Token assembly including the byte that arrives with rx_pkt_end.
  always_comb begin
    tok_nx = tok_q;
    if (rx_data_valid) begin
      if (tok_cnt == 2'd0)      tok_nx[7:0]  = rx_data;
      else if (tok_cnt == 2'd1) tok_nx[10:8] = rx_data[2:0];
    end
    tok_cnt_nx = (rx_data_valid && tok_cnt != 2'd3) ? tok_cnt + 2'd1 : tok_cnt;
    dec_idx    = tok_nx[10:7] - 4'd1;
    tok_ok     = (cur_pid == PID_IN) && !rx_crc_err && (tok_cnt_nx == 2'd2) &&
                 (tok_nx[6:0] == dev_addr) && (tok_nx[10:7] != 4'd0) &&
                 ({1'b0, tok_nx[10:7]} <= NEPS);
  end

  // Per-endpoint muxing: decoded endpoint for the response, latched one for data.
  always_comb begin
    d_stall = 1'b0; d_valid = 1'b0; d_tog = 1'b0;
    s_valid = 1'b0; s_last  = 1'b0; s_data = 8'h00;
    sel_oh  = '0;
    for (int i = 0; i < NUM_EPS; i++) begin
      if (dec_idx == 4'(i)) begin
        d_stall = ep_stall[i];
        d_valid = ep_valid[i];
        d_tog   = toggle[i];
      end
      if (sel == 4'(i)) begin
        s_valid   = ep_valid[i];
        s_last    = ep_last[i];
        s_data    = ep_data[8*i +: 8];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Byte handshake with the source is combinational so the source can advance
  // on the same edge that captures the byte into tx_data.
  always_comb begin
    send     = (state == TX_DATA) && tx_ready && s_valid && (cnt < MAXC);
    ep_ready = send ? sel_oh : '0;
    ack_hit  = (state == WAIT_ACK) && rx_pkt_end && (cur_pid == PID_ACK) && !rx_crc_err;
    to_hit   = (state == WAIT_ACK) && (rx_pkt_end ? !ack_hit : (tcnt == TMAX));
  end

  // Transaction FSM with registered tx and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pid_q         <= 4'h0;
      tok_q         <= '0;
      tok_cnt       <= 2'd0;
      sel           <= 4'd0;
      cnt           <= '0;
      tcnt          <= '0;
      toggle        <= '0;
      tx_pid        <= 4'h0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      tx_pkt_start  <= 1'b0;
      tx_pkt_end    <= 1'b0;
      ep_done       <= '0;
      ep_retry      <= '0;
    end else begin
      tx_data_valid <= 1'b0;
      tx_pkt_start  <= 1'b0;
      tx_pkt_end    <= 1'b0;
      ep_done       <= ack_hit ? sel_oh : '0;
      ep_retry      <= to_hit  ? sel_oh : '0;
      // Clear after the ACK flip so a coincident clear wins.
      toggle        <= (toggle ^ (ack_hit ? sel_oh : '0)) & ~ep_toggle_clr;

      if (rx_pid_valid)      pid_q <= rx_pid;
      else if (rx_pkt_start) pid_q <= 4'h0;

      case (state)
        IDLE: if (rx_pkt_start) begin
          state   <= TOKEN;
          tok_q   <= '0;
          tok_cnt <= 2'd0;
        end
        TOKEN: begin
          tok_q   <= tok_nx;
          tok_cnt <= tok_cnt_nx;
          if (rx_pkt_end) begin
            if (tok_ok) begin
              sel          <= dec_idx;
              tx_pkt_start <= 1'b1;
              cnt          <= '0;
              if (d_stall) begin
                tx_pid <= PID_STALL;
                state  <= HS;
              end else if (!d_valid) begin
                tx_pid <= PID_NAK;
                state  <= HS;
              end else begin
                tx_pid <= d_tog ? PID_DATA1 : PID_DATA0;
                state  <= TX_DATA;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        HS: if (tx_ready) begin
          tx_pkt_end <= 1'b1;
          state      <= IDLE;
        end
        TX_DATA: if (tx_ready) begin
          if (send) begin
            tx_data       <= s_data;
            tx_data_valid <= 1'b1;
            cnt           <= cnt + CW'(1);
            if (s_last || (cnt + CW'(1) == MAXC)) state <= TX_END;
          end else begin
            state <= TX_END;
          end
        end
        TX_END: if (tx_ready) begin
          tx_pkt_end <= 1'b1;
          tcnt       <= '0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          tcnt <= tcnt + TW'(1);
          if (ack_hit || to_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_in_ep_engine.sv
// Scoreboard bench for usb_in_ep_engine: stimulus pushes expected tx/status
// events, a negedge monitor pops and compares each event the DUT emits.
module tb_usb_in_ep_engine;
  localparam int NE = 2, MP = 8, TO = 20;
  localparam logic [3:0] P_IN = 4'h9, P_ACK = 4'h2, P_NAK = 4'hA, P_STALL = 4'hE;
  localparam logic [3:0] P_D0 = 4'h3, P_D1 = 4'hB;
  localparam logic [2:0] K_ST = 3'd0, K_BY = 3'd1, K_EN = 3'd2, K_DN = 3'd3, K_RT = 3'd4;

  typedef struct packed { logic [2:0] k; logic [7:0] v; } ev_t;

  logic clk, rst_n;
  logic [6:0] dev_addr;
  logic [3:0] rx_pid;
  logic rx_pid_valid, rx_data_valid, rx_pkt_start, rx_pkt_end, rx_crc_err;
  logic [7:0] rx_data;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic tx_data_valid, tx_pkt_start, tx_pkt_end, tx_ready, busy;
  logic [8*NE-1:0] ep_data;
  logic [NE-1:0] ep_valid, ep_last, ep_ready, ep_stall, ep_toggle_clr, ep_done, ep_retry;

  usb_in_ep_engine #(.NUM_EPS(NE), .MAX_PKT(MP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr),
    .rx_pid(rx_pid), .rx_pid_valid(rx_pid_valid), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_pkt_start(rx_pkt_start),
    .rx_pkt_end(rx_pkt_end), .rx_crc_err(rx_crc_err),
    .tx_pid(tx_pid), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_pkt_start(tx_pkt_start), .tx_pkt_end(tx_pkt_end), .tx_ready(tx_ready),
    .ep_data(ep_data), .ep_valid(ep_valid), .ep_last(ep_last), .ep_ready(ep_ready),
    .ep_stall(ep_stall), .ep_toggle_clr(ep_toggle_clr), .ep_done(ep_done),
    .ep_retry(ep_retry), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, evt_cnt = 0;
  int rdy0 = 0, rdy1 = 0;
  bit rdy_pat = 1'b0;
  ev_t expq[$];
  logic [8:0] q0[$], q1[$];   // {last, data} per endpoint source

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ex(input logic [2:0] k, input logic [7:0] v);
    ev_t e;
    e.k = k; e.v = v;
    expq.push_back(e);
  endtask

  task automatic mon(input logic [2:0] k, input logic [7:0] v);
    ev_t e;
    evt_cnt++;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0h expected none", k, v);
    end else begin
      e = expq.pop_front();
      if (e.k !== k || e.v !== v) begin
        errors++;
        $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h", k, v, e.k, e.v);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_pkt_start)  mon(K_ST, {4'h0, tx_pid});
      if (tx_data_valid) mon(K_BY, tx_data);
      if (tx_pkt_end)    mon(K_EN, 8'h00);
      if (|ep_done)      mon(K_DN, 8'(ep_done));
      if (|ep_retry)     mon(K_RT, 8'(ep_retry));
    end
  end

  // Endpoint source model: drives after negedge, pops on ep_ready sampled just before posedge.
  always begin
    logic [8:0] tmp;
    @(negedge clk);
    ep_valid[0] = (q0.size() != 0);
    ep_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    ep_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
    ep_valid[1] = (q1.size() != 0);
    ep_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    ep_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
    tx_ready = rdy_pat ? ($urandom_range(0, 3) != 0) : 1'b1;
    #4;
    if (ep_ready[0]) begin
      if (q0.size() != 0) tmp = q0.pop_front();
      rdy0++;
    end
    if (ep_ready[1]) begin
      if (q1.size() != 0) tmp = q1.pop_front();
      rdy1++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                       input logic crc);
    logic [15:0] t;
    t = {5'b0, endp, addr};
    @(negedge clk); rx_pkt_start = 1'b1; rx_pid = pid; rx_pid_valid = 1'b1;
    @(negedge clk); rx_pkt_start = 1'b0; rx_pid_valid = 1'b0; rx_data = t[7:0]; rx_data_valid = 1'b1;
    @(negedge clk); rx_data = t[15:8]; rx_pkt_end = 1'b1; rx_crc_err = crc;
    @(negedge clk); rx_data_valid = 1'b0; rx_pkt_end = 1'b0; rx_crc_err = 1'b0;
  endtask

  task automatic hs(input logic [3:0] pid, input logic [NE-1:0] clr);
    @(negedge clk); rx_pkt_start = 1'b1; rx_pid = pid; rx_pid_valid = 1'b1;
    @(negedge clk); rx_pkt_start = 1'b0; rx_pid_valid = 1'b0; rx_pkt_end = 1'b1; ep_toggle_clr = clr;
    @(negedge clk); rx_pkt_end = 1'b0; ep_toggle_clr = '0;
    tick(1);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (tx_pkt_end !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_tx_pkt_end: got timeout expected tx_pkt_end");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, r;
    rst_n = 1'b0; dev_addr = 7'd5; rx_pid = 4'h0; rx_pid_valid = 1'b0; rx_data = 8'h00;
    rx_data_valid = 1'b0; rx_pkt_start = 1'b0; rx_pkt_end = 1'b0; rx_crc_err = 1'b0;
    ep_stall = '0; ep_toggle_clr = '0;
    tick(3);
    chk("rst_tx_ctl", {28'h0, tx_pkt_start, tx_pkt_end, tx_data_valid, busy}, 32'h0);
    chk("rst_tx_pid_data", {20'h0, tx_pid, tx_data}, 32'h0);
    chk("rst_ep_out", {26'h0, ep_ready, ep_done, ep_retry}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // 4-byte report on EP1 -> DATA0, ACK, then DATA1
    q0.push_back(9'h001); q0.push_back(9'h000); q0.push_back(9'h002); q0.push_back(9'h100);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'h01); ex(K_BY, 8'h00); ex(K_BY, 8'h02); ex(K_BY, 8'h00);
    ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);
    chk("ep1_bytes_consumed", rdy0, 4);
    q0.push_back(9'h111);
    ex(K_ST, {4'h0, P_D1}); ex(K_BY, 8'h11); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);

    // EP2 empty -> NAK, no consumption, toggle stays DATA0
    r = rdy1;
    ex(K_ST, {4'h0, P_NAK}); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd2, 1'b0); wait_end(); tick(3);
    chk("nak_no_ep_ready", rdy1, r);
    chk("nak_idle_after", {31'h0, busy}, 32'h0);
    q1.push_back(9'h122);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'h22); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd2, 1'b0); wait_end();
    ex(K_DN, 8'h02); hs(P_ACK, '0);

    // Wrong address -> silence
    q0.push_back(9'h177);
    r = rdy0; n = evt_cnt;
    token(P_IN, 7'd3, 4'd1, 1'b0); tick(4);
    chk("wrong_addr_silent", evt_cnt, n);
    chk("wrong_addr_no_ready", rdy0, r);

    // Stalled EP1 -> STALL even with data available
    ep_stall = 2'b01;
    ex(K_ST, {4'h0, P_STALL}); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end(); tick(2);
    chk("stall_no_ready", rdy0, r);
    ep_stall = '0;

    // Endpoint out of range (3) and EP0 -> silence
    n = evt_cnt;
    token(P_IN, 7'd5, 4'd3, 1'b0);
    token(P_IN, 7'd5, 4'd0, 1'b0); tick(4);
    chk("ep3_ep0_silent", evt_cnt, n);
    q0.delete(); tick(1);

    // Host silent -> retry; WAIT_ACK counts 0..TO, retry registered when it hits TO
    q0.push_back(9'h0AA); q0.push_back(9'h1BB);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'hAA); ex(K_BY, 8'hBB); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_RT, 8'h01);
    n = 0;
    while (ep_retry !== 2'b01 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_gap_cycles", n, TO + 1);
    tick(2);
    q0.push_back(9'h0AA); q0.push_back(9'h1BB);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'hAA); ex(K_BY, 8'hBB); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);

    // Toggle is DATA1 now; clear it, then a 10-byte report splits 8 + 2 with tx_ready stalls
    @(negedge clk); ep_toggle_clr = 2'b01;
    @(negedge clk); ep_toggle_clr = '0;
    r = rdy0;
    for (int i = 0; i < 10; i++) q0.push_back({(i == 9), 8'(8'h30 + i)});
    ex(K_ST, {4'h0, P_D0});
    for (int i = 0; i < 8; i++) ex(K_BY, 8'(8'h30 + i));
    ex(K_EN, 8'h00);
    rdy_pat = 1'b1;
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);
    ex(K_ST, {4'h0, P_D1}); ex(K_BY, 8'h38); ex(K_BY, 8'h39); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    rdy_pat = 1'b0;
    ex(K_DN, 8'h01); hs(P_ACK, '0);
    chk("split_report_consumed", rdy0 - r, 10);

    // Toggle clear coinciding with ACK wins: next packet is DATA0 again
    q0.push_back(9'h155);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'h55); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, 2'b01);
    q0.push_back(9'h166);
    ex(K_ST, {4'h0, P_D0}); ex(K_BY, 8'h66); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);

    // Token with CRC error -> ignored
    q0.push_back(9'h177);
    n = evt_cnt;
    token(P_IN, 7'd5, 4'd1, 1'b1); tick(4);
    chk("crc_token_silent", evt_cnt, n);
    chk("crc_token_idle", {31'h0, busy}, 32'h0);
    q0.delete(); tick(1);

    // Non-ACK handshake in WAIT_ACK -> retry, toggle unchanged (DATA1 from last ACK)
    q0.push_back(9'h188);
    ex(K_ST, {4'h0, P_D1}); ex(K_BY, 8'h88); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_RT, 8'h01); hs(P_NAK, '0);
    q0.delete();
    q0.push_back(9'h199);
    ex(K_ST, {4'h0, P_D1}); ex(K_BY, 8'h99); ex(K_EN, 8'h00);
    token(P_IN, 7'd5, 4'd1, 1'b0); wait_end();
    ex(K_DN, 8'h01); hs(P_ACK, '0);

    tick(3);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
